// File: rtl/i2s_master_sequencer_if.sv
// Pair-delivery handshake between the I2S capture sequencer and its consumer.
// The master side presents a left/right sample pair; the slave side accepts it with out_ready.
interface i2s_master_sequencer_if #(
  parameter int unsigned SDSIZE = 24
);
  logic [SDSIZE-1:0] out_left;
  logic [SDSIZE-1:0] out_right;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_left, output out_right, output out_valid, input out_ready);
  modport slave  (input out_left, input out_right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_master_sequencer.sv
// I2S master capture sequencer: generates bclk/lrclk, shifts in left/right slots
// (MSB one bit after the lrclk edge) and hands out completed pairs on a valid/ready port.
module i2s_master_sequencer #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned SDSIZE    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic i2s_dout,
  output logic bclk,
  output logic lrclk,
  output logic busy,
  output logic overrun,
  input  logic clr_overrun,
  i2s_master_sequencer_if.master pair
);
  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SDSIZE-1:0] shift;
  logic [SDSIZE-1:0] shift_next;
  logic [SDSIZE-1:0] hold_left;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              frame_end;
  logic              data_bit;
  logic              cap_left;
  logic              cap_pair;
  logic              overwrite;

  assign busy = (state != IDLE);

  always_comb begin
    tick       = (state != IDLE) && (div == DIV_W'(CLK_DIV - 1));
    rise       = tick && !bclk;
    fall       = tick && bclk;
    frame_end  = fall && lrclk && (bit_cnt == BIT_W'(SLOT_BITS - 1));
    data_bit   = (bit_cnt >= BIT_W'(1)) && (bit_cnt <= BIT_W'(SDSIZE));
    shift_next = (shift << 1) | SDSIZE'(i2s_dout);
    cap_left   = rise && !lrclk && (bit_cnt == BIT_W'(SDSIZE));
    cap_pair   = rise && lrclk && (bit_cnt == BIT_W'(SDSIZE));
    overwrite  = cap_pair && pair.out_valid && !pair.out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Stopping only leaves for IDLE on the falling edge that closes the right slot.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (enable) state_next = RUN;
      RUN:      if (!enable) state_next = STOPPING;
      STOPPING: begin
        if (enable)         state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // The frame-end falling toggle naturally returns bclk, lrclk, bit and divider to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div       <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold_left <= '0;
    end else if (state == IDLE) begin
      div     <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (tick) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 1'b1;
      end
      if (fall) begin
        if (bit_cnt == BIT_W'(SLOT_BITS - 1)) begin
          bit_cnt <= '0;
          lrclk   <= ~lrclk;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (rise && data_bit) shift <= shift_next;
      if (cap_left) hold_left <= shift_next;
    end
  end

  // A completing pair always loads; an unaccepted old pair is what flags overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair.out_left  <= '0;
      pair.out_right <= '0;
      pair.out_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (cap_pair) begin
        pair.out_left  <= hold_left;
        pair.out_right <= shift_next;
        pair.out_valid <= 1'b1;
      end else if (pair.out_ready) begin
        pair.out_valid <= 1'b0;
      end
      if (overwrite)        overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_master_sequencer.sv
// Directed bench for i2s_master_sequencer: a codec model drives i2s_dout from the
// observed bclk/lrclk and each scenario task checks timing, pairs, overrun and stop/reset.
`timescale 1ns/1ps
module tb_i2s_master_sequencer;
  localparam int unsigned SD  = 24;
  localparam int unsigned SB  = 32;
  localparam int unsigned CD  = 4;
  localparam int unsigned SD2 = 16;
  localparam int unsigned SB2 = 17;
  localparam int unsigned CD2 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic enable = 1'b0, dout = 1'b0, clr = 1'b0;
  logic bclk, lrclk, busy, overrun;
  logic pre_valid;
  i2s_master_sequencer_if #(.SDSIZE(SD)) pif();
  i2s_master_sequencer #(.CLK_DIV(CD), .SLOT_BITS(SB), .SDSIZE(SD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2s_dout(dout), .bclk(bclk), .lrclk(lrclk),
    .busy(busy), .overrun(overrun), .clr_overrun(clr), .pair(pif.master));

  logic enable2 = 1'b0, dout2 = 1'b0, clr2 = 1'b0;
  logic bclk2, lrclk2, busy2, overrun2;
  i2s_master_sequencer_if #(.SDSIZE(SD2)) pif2();
  i2s_master_sequencer #(.CLK_DIV(CD2), .SLOT_BITS(SB2), .SDSIZE(SD2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .i2s_dout(dout2), .bclk(bclk2), .lrclk(lrclk2),
    .busy(busy2), .overrun(overrun2), .clr_overrun(clr2), .pair(pif2.master));

  // Codec models: change data after each bclk fall, bit 0 of each slot is the delay bit.
  logic [SD-1:0] wl = '0, wr = '0;
  int cbit = 0;
  logic plr = 1'b0;
  always @(negedge bclk) begin
    #1;
    if (lrclk !== plr) cbit = 0; else cbit = cbit + 1;
    plr = lrclk;
    if (cbit >= 1 && cbit <= SD) dout = lrclk ? wr[SD-cbit] : wl[SD-cbit];
    else dout = 1'b0;
  end
  always @(posedge clk) if (!busy) begin cbit = 0; plr = 1'b0; dout = 1'b0; end

  logic [SD2-1:0] wl2 = '0, wr2 = '0;
  int cbit2 = 0;
  logic plr2 = 1'b0;
  always @(negedge bclk2) begin
    #1;
    if (lrclk2 !== plr2) cbit2 = 0; else cbit2 = cbit2 + 1;
    plr2 = lrclk2;
    if (cbit2 >= 1 && cbit2 <= SD2) dout2 = lrclk2 ? wr2[SD2-cbit2] : wl2[SD2-cbit2];
    else dout2 = 1'b0;
  end
  always @(posedge clk) if (!busy2) begin cbit2 = 0; plr2 = 1'b0; dout2 = 1'b0; end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until bclk makes the wanted transition inside slot lr at codec bit b.
  task automatic wait_edge(input logic want_rise, input int lr, input int b, input int limit, input string tag);
    logic pb;
    for (int n = 0; n < limit; n++) begin
      pb = bclk;
      pre_valid = pif.out_valid;
      step();
      if ((bclk === want_rise) && (pb !== want_rise) && (lrclk === lr[0]) && (cbit == b)) return;
    end
    total++; bad++;
    $display("FAIL timeout_%s got=no_edge want=edge", tag);
  endtask

  task automatic wait_edge2(input int lr, input int b, input int limit, input string tag);
    logic pb;
    for (int n = 0; n < limit; n++) begin
      pb = bclk2;
      step();
      if ((bclk2 === 1'b1) && (pb === 1'b0) && (lrclk2 === lr[0]) && (cbit2 == b)) return;
    end
    total++; bad++;
    $display("FAIL timeout_%s got=no_edge want=edge", tag);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    total++; if ({bclk, lrclk, busy, overrun, pif.out_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {bclk, lrclk, busy, overrun, pif.out_valid}); end
    total++; if ({pif.out_left, pif.out_right} !== 48'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {pif.out_left, pif.out_right}); end
    rst = 1'b1;
    repeat (5) step();
    total++; if ({bclk, lrclk, busy} !== 3'b0) begin
      bad++; $display("FAIL idle_hold got=%b want=000", {bclk, lrclk, busy}); end
  endtask

  task automatic test_clocks();
    int r0, r1, l0, l1, misalign, busy_low;
    logic pb, plrk;
    r0 = -1; r1 = -1; l0 = -1; l1 = -1; misalign = 0; busy_low = 0;
    wl = 24'hA5C3F1; wr = 24'h123456; pif.out_ready = 1'b1; enable = 1'b1;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%b want=1", busy); end
    pb = bclk; plrk = lrclk;
    for (int n = 1; n <= 700; n++) begin
      step();
      if (bclk && !pb) begin if (r0 < 0) r0 = n; else if (r1 < 0) r1 = n; end
      if (lrclk !== plrk) begin
        if (!(pb && !bclk)) misalign++;
        if (l0 < 0) l0 = n; else if (l1 < 0) l1 = n;
      end
      if (!busy) busy_low++;
      pb = bclk; plrk = lrclk;
    end
    total++; if (r1 - r0 != 8) begin bad++; $display("FAIL bclk_period got=%0d want=8", r1 - r0); end
    total++; if (l0 < 0 || l1 - l0 != 256) begin bad++; $display("FAIL lrclk_period got=%0d want=256", l1 - l0); end
    total++; if (misalign != 0) begin bad++; $display("FAIL lrclk_on_fall got=%0d want=0", misalign); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL busy_run got=%0d want=0", busy_low); end
  endtask

  task automatic test_pair();
    wait_edge(1'b1, 1, SD, 700, "pair");
    total++; if (pre_valid !== 1'b0 || pif.out_valid !== 1'b1) begin
      bad++; $display("FAIL pair_latency got=%b%b want=01", pre_valid, pif.out_valid); end
    total++; if ({pif.out_left, pif.out_right} !== {24'hA5C3F1, 24'h123456}) begin
      bad++; $display("FAIL pair_data got=%h want=a5c3f1123456", {pif.out_left, pif.out_right}); end
    step();
    total++; if (pif.out_valid !== 1'b0) begin bad++; $display("FAIL pair_pulse got=%b want=0", pif.out_valid); end
  endtask

  task automatic test_overrun();
    pif.out_ready = 1'b0; wl = 24'hC0FFEE; wr = 24'h00BEEF;
    wait_edge(1'b1, 1, SD, 700, "ovr_a");
    total++; if ({pif.out_valid, pif.out_left, pif.out_right, overrun} !== {1'b1, 24'hC0FFEE, 24'h00BEEF, 1'b0}) begin
      bad++; $display("FAIL ovr_first got=%h want=%h", {pif.out_valid, pif.out_left, pif.out_right, overrun},
                      {1'b1, 24'hC0FFEE, 24'h00BEEF, 1'b0}); end
    wl = 24'h800001; wr = 24'h7FFFFE;
    repeat (100) step();
    total++; if ({pif.out_valid, pif.out_left} !== {1'b1, 24'hC0FFEE}) begin
      bad++; $display("FAIL ovr_hold got=%h want=1c0ffee", {pif.out_valid, pif.out_left}); end
    wait_edge(1'b1, 1, SD, 700, "ovr_b");
    total++; if ({pif.out_left, pif.out_right} !== {24'h800001, 24'h7FFFFE}) begin
      bad++; $display("FAIL ovr_replace got=%h want=8000017ffffe", {pif.out_left, pif.out_right}); end
    total++; if ({overrun, pif.out_valid} !== 2'b11) begin
      bad++; $display("FAIL ovr_set got=%b want=11", {overrun, pif.out_valid}); end
    wl = 24'h5A5A5A; wr = 24'hA5A5A5;
    clr = 1'b1; step(); clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    wait_edge(1'b0, 1, SD, 700, "ovr_c_fall");
    repeat (CD - 1) step();
    clr = 1'b1; step(); clr = 1'b0;
    total++; if ({bclk, pif.out_right} !== {1'b1, 24'hA5A5A5}) begin
      bad++; $display("FAIL ovr_coincide_load got=%h want=1a5a5a5", {bclk, pif.out_right}); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b want=1", overrun); end
    wl = 24'h13579B; wr = 24'h2468AC;
    clr = 1'b1; step(); clr = 1'b0;
    pif.out_ready = 1'b1; step(); pif.out_ready = 1'b0;
    total++; if ({pif.out_valid, overrun} !== 2'b00) begin
      bad++; $display("FAIL ovr_accept got=%b want=00", {pif.out_valid, overrun}); end
    wait_edge(1'b1, 1, SD, 700, "ovr_d");
    total++; if ({pif.out_valid, overrun, pif.out_left, pif.out_right} !== {2'b10, 24'h13579B, 24'h2468AC}) begin
      bad++; $display("FAIL ovr_fresh got=%h want=%h", {pif.out_valid, overrun, pif.out_left, pif.out_right},
                      {2'b10, 24'h13579B, 24'h2468AC}); end
    wl = 24'hFEDCBA; wr = 24'h010203;
    wait_edge(1'b0, 1, SD, 700, "ovr_e_fall");
    repeat (CD - 1) step();
    pif.out_ready = 1'b1; step();
    total++; if ({pif.out_valid, overrun, pif.out_left, pif.out_right} !== {2'b10, 24'hFEDCBA, 24'h010203}) begin
      bad++; $display("FAIL ready_same_cycle got=%h want=%h", {pif.out_valid, overrun, pif.out_left, pif.out_right},
                      {2'b10, 24'hFEDCBA, 24'h010203}); end
    step();
    total++; if (pif.out_valid !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b want=0", pif.out_valid); end
  endtask

  task automatic test_stop();
    logic pb, plrk;
    int pcb, found, idle_bad, gaps, busy_low, last;
    found = 0; idle_bad = 0; gaps = 0; busy_low = 0; last = 0; pcb = 0; pb = 1'b0; plrk = 1'b0;
    wl = 24'h3C3C3C; wr = 24'hC3C3C3;
    wait_edge(1'b1, 0, 5, 700, "stop_arm");
    enable = 1'b0;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stopping_busy got=%b want=1", busy); end
    wait_edge(1'b1, 1, SD, 700, "stop_pair");
    total++; if ({pif.out_valid, pif.out_left, pif.out_right} !== {1'b1, 24'h3C3C3C, 24'hC3C3C3}) begin
      bad++; $display("FAIL stop_pair got=%h want=13c3c3cc3c3c3", {pif.out_valid, pif.out_left, pif.out_right}); end
    for (int n = 0; n < 300; n++) begin
      pb = bclk; plrk = lrclk; pcb = cbit;
      step();
      if (!busy) begin found = 1; break; end
    end
    total++; if (!(found == 1 && pb && plrk && pcb == SB - 1)) begin
      bad++; $display("FAIL stop_frame_end got=%0d%b%b_%0d want=111_%0d", found, pb, plrk, pcb, SB - 1); end
    total++; if ({bclk, lrclk} !== 2'b00) begin bad++; $display("FAIL stop_idle_pins got=%b want=00", {bclk, lrclk}); end
    for (int n = 0; n < 20; n++) begin
      step();
      if (bclk || lrclk || busy) idle_bad++;
    end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_quiet got=%0d want=0", idle_bad); end
    enable = 1'b1;
    wait_edge(1'b1, 0, 2, 700, "reen_arm");
    pb = bclk;
    for (int n = 1; n <= 600; n++) begin
      step();
      if (n == 10) enable = 1'b0;
      if (n == 60) enable = 1'b1;
      if (bclk !== pb) begin
        if (n - last != CD) gaps++;
        last = n;
      end
      if (!busy) busy_low++;
      pb = bclk;
    end
    total++; if (gaps != 0) begin bad++; $display("FAIL reenable_gap got=%0d want=0", gaps); end
    total++; if (busy_low != 0) begin bad++; $display("FAIL reenable_busy got=%0d want=0", busy_low); end
  endtask

  task automatic test_reset_mid();
    int stray;
    logic seen;
    stray = 0; seen = 1'b0;
    wl = 24'h0F1E2D; wr = 24'h3C4B5A;
    wait_edge(1'b1, 1, 10, 700, "rmid_arm");
    rst = 1'b0;
    #1;
    total++; if ({bclk, lrclk, busy, overrun, pif.out_valid} !== 5'b0) begin
      bad++; $display("FAIL rmid_ctl got=%b want=00000", {bclk, lrclk, busy, overrun, pif.out_valid}); end
    total++; if ({pif.out_left, pif.out_right} !== 48'h0) begin
      bad++; $display("FAIL rmid_data got=%h want=0", {pif.out_left, pif.out_right}); end
    enable = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (pif.out_valid || busy) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL rmid_no_pair got=%0d want=0", stray); end
    wl = 24'h6B8E21; wr = 24'h9D4C07; enable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bclk) begin seen = 1'b1; break; end
    end
    total++; if ({seen, lrclk} !== 2'b10) begin bad++; $display("FAIL restart_left got=%b want=10", {seen, lrclk}); end
    wait_edge(1'b1, 1, SD, 700, "restart_pair");
    total++; if ({pif.out_valid, pif.out_left, pif.out_right} !== {1'b1, 24'h6B8E21, 24'h9D4C07}) begin
      bad++; $display("FAIL restart_pair got=%h want=16b8e219d4c07", {pif.out_valid, pif.out_left, pif.out_right}); end
    enable = 1'b0;
  endtask

  task automatic test_small();
    int r0, r1;
    logic pb;
    r0 = -1; r1 = -1;
    wl2 = 16'hBEEF; wr2 = 16'h1357; pif2.out_ready = 1'b1; enable2 = 1'b1;
    pb = bclk2;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (bclk2 && !pb) begin if (r0 < 0) r0 = n; else if (r1 < 0) r1 = n; end
      pb = bclk2;
    end
    total++; if (r0 < 0 || r1 - r0 != 2) begin bad++; $display("FAIL small_period got=%0d want=2", r1 - r0); end
    wait_edge2(1, SD2, 200, "small_a");
    total++; if ({pif2.out_valid, pif2.out_left, pif2.out_right} !== {1'b1, 16'hBEEF, 16'h1357}) begin
      bad++; $display("FAIL small_pair_a got=%h want=1beef1357", {pif2.out_valid, pif2.out_left, pif2.out_right}); end
    wl2 = 16'h8001; wr2 = 16'h7FFE;
    wait_edge2(1, SD2, 200, "small_b");
    total++; if ({pif2.out_valid, pif2.out_left, pif2.out_right} !== {1'b1, 16'h8001, 16'h7FFE}) begin
      bad++; $display("FAIL small_pair_b got=%h want=180017ffe", {pif2.out_valid, pif2.out_left, pif2.out_right}); end
    enable2 = 1'b0;
  endtask

  initial begin
    pif.out_ready  = 1'b0;
    pif2.out_ready = 1'b0;
    test_reset();
    test_clocks();
    test_pair();
    test_overrun();
    test_stop();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/i2s_master_sequencer.md
Name: i2s_master_sequencer

Overview:
I2S master-side controller for the stereo capture path. It derives bclk and lrclk from the system clock and sequences each frame: left slot, then right slot, MSB one bit after the lrclk edge. It samples i2s_dout and delivers each completed left/right pair on a valid/ready handshake. Enable and disable take effect only on frame boundaries, so the codec never sees a truncated frame.

Parameters:
CLK_DIV, 4, clk cycles per bclk half-period (legal range 1..255); bclk period = 2*CLK_DIV clk cycles
SLOT_BITS, 32, bclk periods per slot (one slot per channel); must be greater than SDSIZE
SDSIZE, 24, data bits per channel, MSB first

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  request to run the bus; sampled on frame boundaries only
i2s_dout  input  1  serial data from the codec
bclk  output  1  generated bit clock, registered
lrclk  output  1  generated word select; 0 = left, 1 = right; registered
busy  output  1  high in RUN or STOPPING
out_left  output  SDSIZE  captured left sample
out_right  output  SDSIZE  captured right sample
out_valid  output  1  pair available
out_ready  input  1  consumer accepts the pair when out_valid and out_ready are both high
overrun  output  1  sticky flag: a pair was overwritten before it was accepted
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - bclk=0, lrclk=0, busy=0, out_valid=0, overrun=0.
  - out_left and out_right go to 0; divider, bit counter and shift register are cleared.
  - Reset asserted mid-frame aborts the frame immediately; no partial pair is delivered.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: bclk and lrclk are held at 0. When enable=1, the next clk goes to RUN with divider=0, bit=0, slot=left, lrclk=0.
  - RUN: the divider counts 0..CLK_DIV-1. At terminal count bclk toggles and the divider returns to 0.
  - RUN with enable=0: go to STOPPING.
  - STOPPING: operates exactly as RUN. At the falling edge that ends bit SLOT_BITS-1 of the right slot, go to IDLE with bclk=0 and lrclk=0.
  - STOPPING with enable=1 again: return to RUN with no gap in bclk.
  - IDLE is entered only at a frame end.
- Bit timing (all actions are on the clk edge where bclk is toggled):
  - On a bclk falling toggle, bit increments.
  - Wrap from SLOT_BITS-1 to 0 toggles lrclk. This makes the lrclk change coincide with a bclk falling edge.
  - On a bclk rising toggle, i2s_dout is sampled when 1 <= bit <= SDSIZE (bit 1 is the MSB) and shifted into an SDSIZE shift register.
  - All other bits are ignored (padding).
- Pair assembly:
  - At the rising toggle of left bit SDSIZE, the shift result goes to a left holding register.
  - At the rising toggle of right bit SDSIZE, out_left takes the holding value, out_right takes the shift result, and out_valid=1 on the following clk.
- Handshake:
  - out_valid stays high until the cycle where out_ready=1, then drops on the next clk.
  - out_left and out_right are stable while out_valid=1, except on overwrite.
- Overwrite:
  - If a new pair completes while out_valid=1 and out_ready=0, the new pair replaces the old one, out_valid stays 1 and overrun is set.
  - If out_ready=1 in that same cycle, the old pair counts as accepted, the new pair loads, and there is no overrun.
- clr_overrun clears overrun. If an overrun event occurs in the same cycle, set wins.
- Latency: from the rising bclk toggle that samples right bit SDSIZE to out_valid=1 is 1 clk.
- busy=1 from the first RUN cycle through the last STOPPING cycle.
- bclk and lrclk are plain registers: glitch-free, with no combinational path from inputs.

Test Plan:
1. Reset then enable=1 with CLK_DIV=4, SLOT_BITS=32 -> bclk period 8 clk; lrclk toggles every 256 clk; each lrclk edge lands on a bclk falling edge; busy=1.
2. Codec model drives left=0xA5C3F1 and right=0x123456, out_ready=1 -> one out_valid pulse with out_left=0xA5C3F1 and out_right=0x123456, 1 clk after right bit 24 is sampled.
3. out_ready=0 for 2 frames -> the first pair is held, then overwritten by the second pair; overrun=1. clr_overrun pulse -> overrun=0. A clr_overrun pulse coinciding with a new overwrite -> overrun stays 1.
4. enable dropped mid-left-slot -> frame completes through right bit 31, the pair is delivered, then IDLE with bclk=0, lrclk=0, busy=0. Re-enable during STOPPING -> bclk continues without a gap.
5. rst asserted mid-right-slot -> all outputs 0 immediately and no out_valid. enable after release -> the new frame starts with a left slot.
6. CLK_DIV=1, SDSIZE=16, SLOT_BITS=17 -> bclk period 2 clk; 16-bit pairs are captured correctly with no padding bits.
